// File: rtl/fp_exp_align_pipe.sv
// fp_exp_align_pipe
//   Exponent compare and significand alignment front end for the FP adder.
//   Picks the operand with the larger effective exponent, reports the exponent
//   difference, and right-aligns the smaller significand with guard/round/sticky
//   bits. The work is split over two registered stages with valid/ready flow control.
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   in_valid / in_ready        operand pair handshake (in_ready is combinational)
//   exp_a, exp_b [EXP_W]       biased exponent fields
//   man_a, man_b [MAN_W]       stored fraction fields
//   out_valid / out_ready      result handshake
//   exp_big [EXP_W]            effective exponent of the larger operand
//   diff [EXP_W]               |eff_a - eff_b|
//   swapped                    1 = operand b had the larger effective exponent
//   sig_big [SIG_W]            significand of the larger operand
//   sig_small_al [SIG_W+3]     smaller significand shifted right by diff, LSB = sticky
module fp_exp_align_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int SIG_W = MAN_W + 1,
  localparam int EXT_W = SIG_W + 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic [MAN_W-1:0] man_a,
  input  logic [MAN_W-1:0] man_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] exp_big,
  output logic [EXP_W-1:0] diff,
  output logic             swapped,
  output logic [SIG_W-1:0] sig_big,
  output logic [EXT_W-1:0] sig_small_al
);

  logic en1, en2;

  // stage 1 state
  logic             v1_q;
  logic [EXP_W-1:0] exp_big1_q, diff1_q;
  logic             swp1_q;
  logic [SIG_W-1:0] sig_big1_q, sig_small1_q;

  // stage 2 state
  logic             v2_q;
  logic [EXP_W-1:0] exp_big2_q, diff2_q;
  logic             swp2_q;
  logic [SIG_W-1:0] sig_big2_q;
  logic [EXT_W-1:0] sal2_q;

  // A stage may load when it is empty or the stage after it is draining.
  assign en2      = !v2_q | out_ready;
  assign en1      = !v1_q | en2;
  assign in_ready = en1 & !reset;

  // ---------------- stage 1: compare and swap ----------------
  logic [EXP_W-1:0] eff_a, eff_b, sub_lo;
  logic [EXP_W:0]   sub;
  logic [SIG_W-1:0] sig_a, sig_b;
  logic             swp_d;
  logic [EXP_W-1:0] diff_d, exp_big_d;
  logic [SIG_W-1:0] sig_big_d, sig_small_d;

  always_comb begin
    // subnormals share the exponent of the smallest normal and lose the hidden bit
    eff_a  = (exp_a == '0) ? EXP_W'(1) : exp_a;
    eff_b  = (exp_b == '0) ? EXP_W'(1) : exp_b;
    sig_a  = {exp_a != '0, man_a};
    sig_b  = {exp_b != '0, man_b};
    // the extra top bit of the zero-extended subtract is the borrow, i.e. eff_b > eff_a
    sub    = {1'b0, eff_a} - {1'b0, eff_b};
    sub_lo = sub[EXP_W-1:0];
    swp_d  = sub[EXP_W];
    diff_d = swp_d ? -sub_lo : sub_lo;
    exp_big_d   = swp_d ? eff_b : eff_a;
    sig_big_d   = swp_d ? sig_b : sig_a;
    sig_small_d = swp_d ? sig_a : sig_b;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q         <= 1'b0;
      exp_big1_q   <= '0;
      diff1_q      <= '0;
      swp1_q       <= 1'b0;
      sig_big1_q   <= '0;
      sig_small1_q <= '0;
    end else if (en1) begin
      v1_q         <= in_valid;
      exp_big1_q   <= exp_big_d;
      diff1_q      <= diff_d;
      swp1_q       <= swp_d;
      sig_big1_q   <= sig_big_d;
      sig_small1_q <= sig_small_d;
    end
  end

  // ---------------- stage 2: align with sticky ----------------
  logic [EXT_W-1:0] ext, shifted, lost, sal_d;

  always_comb begin
    ext     = {sig_small1_q, 3'b000};
    shifted = '0;
    lost    = '0;
    if (int'(diff1_q) < EXT_W) begin
      shifted = ext >> diff1_q;
      lost    = ext & ~({EXT_W{1'b1}} << diff1_q);
      sal_d   = {shifted[EXT_W-1:1], shifted[0] | (|lost)};
    end else begin
      // everything falls off the end; only the sticky survives
      sal_d   = {{(EXT_W-1){1'b0}}, |sig_small1_q};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2_q       <= 1'b0;
      exp_big2_q <= '0;
      diff2_q    <= '0;
      swp2_q     <= 1'b0;
      sig_big2_q <= '0;
      sal2_q     <= '0;
    end else if (en2) begin
      v2_q       <= v1_q;
      exp_big2_q <= exp_big1_q;
      diff2_q    <= diff1_q;
      swp2_q     <= swp1_q;
      sig_big2_q <= sig_big1_q;
      sal2_q     <= sal_d;
    end
  end

  assign out_valid    = v2_q;
  assign exp_big      = exp_big2_q;
  assign diff         = diff2_q;
  assign swapped      = swp2_q;
  assign sig_big      = sig_big2_q;
  assign sig_small_al = sal2_q;

endmodule

// File: tb/tb_fp_exp_align_pipe.sv
// Testbench for fp_exp_align_pipe (EXP_W=8, MAN_W=23). A negedge monitor keeps a
// scoreboard of expected results pushed at accept and popped at output transfer,
// and checks output stability while stalled; scenario tasks add their own checks.
module tb_fp_exp_align_pipe;
  typedef struct packed {
    logic [7:0]  eb;
    logic [7:0]  d;
    logic        sw;
    logic [23:0] sb;
    logic [26:0] sa;
  } res_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [7:0]  exp_a = '0, exp_b = '0;
  logic [22:0] man_a = '0, man_b = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [7:0]  exp_big, diff;
  logic        swapped;
  logic [23:0] sig_big;
  logic [26:0] sig_small_al;

  int   total = 0, bad = 0;
  res_t sbq[$];
  res_t held;
  logic held_v = 1'b0;

  fp_exp_align_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .exp_a(exp_a), .exp_b(exp_b), .man_a(man_a), .man_b(man_b),
    .out_valid(out_valid), .out_ready(out_ready), .exp_big(exp_big), .diff(diff),
    .swapped(swapped), .sig_big(sig_big), .sig_small_al(sig_small_al)
  );

  always #5 clk = ~clk;

  // bit-serial reference: shift one place at a time, collecting lost bits
  function automatic res_t model(input logic [7:0] ea, eb, input logic [22:0] ma, mb);
    int a, b;
    logic [23:0] sga, sgb;
    logic [26:0] x;
    logic st;
    res_t r;
    a = (ea == 0) ? 1 : int'(ea);
    b = (eb == 0) ? 1 : int'(eb);
    sga = {ea != 0, ma};
    sgb = {eb != 0, mb};
    if (b > a) begin
      r.sw = 1'b1; r.eb = 8'(b); r.d = 8'(b - a); r.sb = sgb; x = {sga, 3'b000};
    end else begin
      r.sw = 1'b0; r.eb = 8'(a); r.d = 8'(a - b); r.sb = sga; x = {sgb, 3'b000};
    end
    st = 1'b0;
    for (int i = 0; i < int'(r.d); i++) begin
      st = st | x[0];
      x  = x >> 1;
    end
    x[0] = x[0] | st;
    r.sa = x;
    return r;
  endfunction

  res_t mo, me;
  always @(negedge clk) begin
    if (!reset) begin
      mo = {exp_big, diff, swapped, sig_big, sig_small_al};
      if (held_v && out_valid) begin
        total++;
        if (mo !== held) begin
          bad++;
          $display("FAIL stall_stable got=%h held=%h", mo, held);
        end
      end
      held_v = out_valid && !out_ready;
      held   = mo;
      if (out_valid && out_ready) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL scoreboard unexpected beat got=%h", mo);
        end else begin
          me = sbq.pop_front();
          if (mo !== me) begin
            bad++;
            $display("FAIL scoreboard got eb=%h d=%h sw=%b sb=%h sa=%h need eb=%h d=%h sw=%b sb=%h sa=%h",
                     mo.eb, mo.d, mo.sw, mo.sb, mo.sa, me.eb, me.d, me.sw, me.sb, me.sa);
          end
        end
      end
      if (in_valid && in_ready) sbq.push_back(model(exp_a, exp_b, man_a, man_b));
    end
  end

  task automatic set_in(input logic [7:0] ea, eb, input logic [22:0] ma, mb);
    exp_a = ea; exp_b = eb; man_a = ma; man_b = mb;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while ((sbq.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (sbq.size() != 0 || out_valid) begin
      bad++;
      $display("FAIL drain_timeout left=%0d need=0", sbq.size());
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({out_valid, exp_big, diff, swapped, sig_big, sig_small_al, in_ready} !== '0) begin
      bad++;
      $display("FAIL reset_state ov=%b eb=%h d=%h sw=%b sb=%h sa=%h ir=%b need all 0",
               out_valid, exp_big, diff, swapped, sig_big, sig_small_al, in_ready);
    end
    @(negedge clk); reset = 1'b0; #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b need=1", in_ready); end
    @(posedge clk); #1;
  endtask

  // single beat, exact 2-cycle latency, result against hand-derived constants
  task automatic test_vector(input string nm, input logic [7:0] ea, eb,
                             input logic [22:0] ma, mb, input res_t want);
    res_t got;
    out_ready = 1'b1;
    set_in(ea, eb, ma, mb); in_valid = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL %s accept got=%b need=1", nm, in_ready); end
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL %s early_valid got=%b need=0", nm, out_valid); end
    @(negedge clk);
    got = {exp_big, diff, swapped, sig_big, sig_small_al};
    total++;
    if (out_valid !== 1'b1 || got !== want) begin
      bad++;
      $display("FAIL %s ov=%b got eb=%h d=%h sw=%b sb=%h sa=%h need eb=%h d=%h sw=%b sb=%h sa=%h",
               nm, out_valid, got.eb, got.d, got.sw, got.sb, got.sa,
               want.eb, want.d, want.sw, want.sb, want.sa);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_in(8'($urandom_range(0, 40)), 8'($urandom_range(0, 40)), 23'($urandom), 23'($urandom));
      in_valid = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready beat=%0d got=%b need=1", i, in_ready); end
      @(posedge clk); #1;
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [7:0] ea[5], eb[5];
    logic [22:0] ma[5], mb[5];
    int idx = 0, n = 0;
    for (int i = 0; i < 5; i++) begin
      ea[i] = 8'($urandom_range(1, 60)); eb[i] = 8'($urandom_range(1, 60));
      ma[i] = 23'($urandom); mb[i] = 23'($urandom);
    end
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      set_in(ea[idx], eb[idx], ma[idx], mb[idx]); in_valid = 1'b1;
      @(negedge clk); if (in_ready) idx++;
      @(posedge clk); #1;
    end
    total++;
    if (idx != 2 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_fill accepted=%0d ir=%b need 2 and 0", idx, in_ready);
    end
    out_ready = 1'b1;
    while (idx < 5 && n < 40) begin
      set_in(ea[idx], eb[idx], ma[idx], mb[idx]); in_valid = 1'b1;
      @(negedge clk); if (in_ready) idx++;
      @(posedge clk); #1; n++;
    end
    total++;
    if (idx != 5) begin bad++; $display("FAIL bp_accept_all got=%0d need=5", idx); end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      case ($urandom_range(0, 3))
        0: set_in(8'($urandom_range(0, 2)), 8'($urandom_range(0, 2)), 23'($urandom), 23'($urandom));
        1: set_in(8'($urandom), 8'($urandom), 23'($urandom), 23'($urandom));
        default: set_in(8'($urandom_range(100, 140)), 8'($urandom_range(100, 140)),
                        23'($urandom), 23'($urandom));
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    set_in(8'h10, 8'h12, 23'h1, 23'h2); in_valid = 1'b1;
    @(posedge clk); #1;
    set_in(8'h20, 8'h05, 23'h3, 23'h4);
    @(posedge clk); #2;
    reset = 1'b1; in_valid = 1'b0; #1;
    total++;
    if ({out_valid, exp_big, diff, swapped, sig_big, sig_small_al, in_ready} !== '0) begin
      bad++;
      $display("FAIL midreset_clear ov=%b eb=%h d=%h sw=%b sb=%h sa=%h ir=%b need all 0",
               out_valid, exp_big, diff, swapped, sig_big, sig_small_al, in_ready);
    end
    sbq.delete(); held_v = 1'b0;
    @(posedge clk); @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_flushed got=%b need=0", out_valid); end
    test_vector("post_reset", 8'h80, 8'h81, 23'h0, 23'h0, {8'h81, 8'h01, 1'b1, 24'h800000, 27'h2000000});
  endtask

  initial begin
    test_reset();
    test_vector("v1_b_bigger", 8'h80, 8'h81, 23'h0, 23'h0, {8'h81, 8'h01, 1'b1, 24'h800000, 27'h2000000});
    test_vector("v2_equal", 8'h02, 8'h02, 23'h000001, 23'h7FFFFF, {8'h02, 8'h00, 1'b0, 24'h800001, 27'h7FFFFF8});
    test_vector("v3_subnorm_a", 8'h00, 8'h02, 23'h400000, 23'h0, {8'h02, 8'h01, 1'b1, 24'h800000, 27'h1000000});
    test_vector("v4_diff158", 8'h9F, 8'h01, 23'h0, 23'h1, {8'h9F, 8'h9E, 1'b0, 24'h800000, 27'h0000001});
    test_vector("diff25", 8'h1A, 8'h01, 23'h0, 23'h400000, {8'h1A, 8'h19, 1'b0, 24'h800000, 27'h0000003});
    test_vector("diff26", 8'h1B, 8'h01, 23'h0, 23'h400000, {8'h1B, 8'h1A, 1'b0, 24'h800000, 27'h0000001});
    test_vector("diff27", 8'h1C, 8'h01, 23'h0, 23'h400000, {8'h1C, 8'h1B, 1'b0, 24'h800000, 27'h0000001});
    test_vector("zero_small", 8'h20, 8'h00, 23'h0, 23'h0, {8'h20, 8'h1F, 1'b0, 24'h800000, 27'h0000000});
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
